lfsr_core: RTL and testbench
============================

Name: lfsr_core

Overview:
- Fibonacci-style linear feedback shift register producing a pseudo-random state sequence on every enabled clock edge.
- Default configuration is a 3-bit maximal-length generator, polynomial x^3+x^2+1, period 7.
- Used as a lightweight pattern and test-vector source inside datapath and BIST blocks.

Parameters:
- WIDTH, 3, register width in bits; legal range 2..32.
- TAPS, 3'b110, feedback tap mask; bit i set means q[i] enters the XOR. Width is WIDTH.
- SEED, 3'b001, reset and recovery state; must be nonzero. Width is WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance enable; 1 = shift on this edge.
- load  input  1  synchronous load of seed_in.
- seed_in  input  WIDTH  value to load when load=1.
- q  output  WIDTH  current register state.
- serial_out  output  1  equals q[WIDTH-1], combinational from the register.
- at_seed  output  1  combinational; 1 when q == SEED.

Behaviour:
- One clock domain. All state changes occur on the rising edge of clk.
- Feedback: fb = XOR-reduce(q & TAPS).
- Next state when advancing: {q[WIDTH-2:0], fb}, i.e. shift toward the MSB with fb entering at bit 0.
- Priority per edge: rst, then load, then en, then hold.
  - rst=1: q <= SEED, regardless of load and en.
  - load=1: q <= seed_in, subject to the lockup guard below.
  - en=1: q <= next state.
  - otherwise q holds its value.
- Reset values: q = SEED (3'b001 by default), serial_out = SEED[WIDTH-1], at_seed = 1.
- Latency: q changes one edge after the controlling input is sampled. There is no pipeline.
- Default sequence from 001 with en=1: 001, 010, 101, 011, 111, 110, 100, then back to 001. at_seed is high every 7th state.
- Reset asserted mid-sequence: the next edge forces 001, and advancing resumes on the first edge with rst=0 and en=1.
- load and en both high: the load wins and no shift occurs on that edge.
- No X propagation: every register bit is defined after the first edge with rst=1.

Optional Feature:
- Macro LFSR_LOCKUP_GUARD_EN.
- Defined:
  - A load with seed_in == 0 loads SEED instead.
  - If q is ever all-zero while en=1, the next state is SEED rather than 0.
  - This guarantees the register never locks up.
- Undefined:
  - seed_in is loaded verbatim, including 0.
  - The all-zero state is self-sustaining: q stays 0 until rst or a nonzero load.

Decomposition:
- Shared package lfsr_pkg holds:
  - Default maximal-length tap constants for widths 2..16 (width 3 is 3'b110).
  - Default seed constant.
  - A pure function computing the next state from the current state and the tap mask.
- No sub-module is needed. The feedback and next-state logic stays inline, driven by the package function.

Test Plan:
- Reset: hold rst=1 for one edge with en=1 -> q=001, at_seed=1, serial_out=0.
- Free run: release rst, en=1 for 7 edges -> q steps 010, 101, 011, 111, 110, 100, 001; at_seed is high only at 001.
- Hold: en=0 for 3 edges starting at q=101 -> q stays 101.
- Load priority: load=1, seed_in=110, en=1 -> q=110; the next en edge gives 100.
- Reset mid-run: rst=1 while q=111 -> q=001 on that edge; with rst=0 and en=1 the next edge gives 010.
- Lockup: load seed_in=000, then en=1.
  - With LFSR_LOCKUP_GUARD_EN: q=001 after the load.
  - Without it: q=000 and stays 000 for 3 or more edges.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for lfsr_core: default maximal-length tap
// masks for widths 2..16, the default seed, and the next-state function.
package lfsr_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  // Seed used when the instantiating block gives none; any nonzero value works.
  localparam logic [MAX_WIDTH-1:0] DEFAULT_SEED = 32'd1;

  // Maximal-length Fibonacci tap masks. Bit i set means q[i] feeds the XOR.
  // Widths outside 2..16 return 0 so a missing TAPS override is obvious.
  function automatic logic [MAX_WIDTH-1:0] lfsr_default_taps(input int unsigned width);
    logic [MAX_WIDTH-1:0] taps;
    case (width)
      2:       taps = 32'h0000_0003;
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

  // One Fibonacci step: XOR-reduce the tapped bits and shift that value in
  // at bit 0, pushing the register toward the MSB. Bits at or above width
  // are cleared so callers can truncate the result safely.
  function automatic logic [MAX_WIDTH-1:0] lfsr_next(
    input logic [MAX_WIDTH-1:0] state,
    input logic [MAX_WIDTH-1:0] taps,
    input int unsigned          width
  );
    logic                 fb;
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] shifted;
    fb      = ^(state & taps);
    mask    = (width >= MAX_WIDTH) ? '1 : ((32'd1 << width) - 32'd1);
    shifted = {state[MAX_WIDTH-2:0], fb};
    return shifted & mask;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR with synchronous reset, synchronous load and advance enable.
// Edge priority: rst, then load, then en, then hold.
// Build option: LFSR_LOCKUP_GUARD_EN -- when defined, a zero load is replaced
// by SEED and an all-zero register advances to SEED, so the register can
// never stick at zero. When undefined, zero is loaded verbatim and is a
// self-sustaining state.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             at_seed
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] step_value;
  logic [WIDTH-1:0] load_value;

  // Candidate values for a shift edge and for a load edge.
  always_comb begin
    step_value = WIDTH'(lfsr_next(MAX_WIDTH'(state), MAX_WIDTH'(TAPS), WIDTH));
    load_value = seed_in;
`ifdef LFSR_LOCKUP_GUARD_EN
    // Zero is the one state an XOR LFSR can never leave; steer it to SEED.
    if (state == '0) begin
      step_value = SEED;
    end
    if (seed_in == '0) begin
      load_value = SEED;
    end
`endif
  end

  // State register with rst > load > en > hold priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= load_value;
    end else if (en) begin
      state <= step_value;
    end
  end

  assign q          = state;
  assign serial_out = state[WIDTH-1];
  assign at_seed    = (state == SEED);

endmodule

// File: tb/tb_lfsr_core.sv
// Testbench for lfsr_core in its default 3-bit configuration.
// Directed table of edges, a lockup sequence, then randomized traffic
// compared against an arithmetic reference model.
module tb_lfsr_core;

  localparam int W = 3;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] seed_in = '0;
  logic [W-1:0] q;
  logic         serial_out;
  logic         at_seed;

  always #5 clk = ~clk;

  lfsr_core dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .seed_in    (seed_in),
    .q          (q),
    .serial_out (serial_out),
    .at_seed    (at_seed)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] seed;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t tbl[$];

`ifdef LFSR_LOCKUP_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // ---------------- reference model ----------------
  // Polynomial x^3+x^2+1: feedback is the parity of bits 2 and 1, the
  // register doubles (mod 8) and the feedback fills bit 0.
  function automatic int model_step(input int cur);
    int fb;
    if (GUARD && cur == 0) return 1;
    fb = (((cur >> 2) & 1) + ((cur >> 1) & 1)) % 2;
    return (cur * 2) % 8 + fb;
  endfunction

  function automatic int model_edge(input int cur, input bit r, input bit e,
                                    input bit l, input int s);
    if (r) return 1;
    if (l) return (GUARD && s == 0) ? 1 : s;
    if (e) return model_step(cur);
    return cur;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [W-1:0] exp_v);
    vec_cnt++;
    if (q !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: q=%b expected %b", name, q, exp_v);
    end
    vec_cnt++;
    if (serial_out !== exp_v[W-1]) begin
      err_cnt++;
      $display("FAIL %s serial_out: got %b expected %b", name, serial_out, exp_v[W-1]);
    end
    vec_cnt++;
    if (at_seed !== (exp_v == 3'b001)) begin
      err_cnt++;
      $display("FAIL %s at_seed: got %b expected %b", name, at_seed, (exp_v == 3'b001));
    end
  endtask

  // Drive inputs, let one rising edge sample them, then settle before checks.
  task automatic drive(input bit r, input bit e, input bit l, input logic [W-1:0] s);
    rst = r; en = e; load = l; seed_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit r, input bit e, input bit l,
                     input logic [W-1:0] s, input logic [W-1:0] x);
    vec_t v;
    v.rst = r; v.en = e; v.load = l; v.seed = s; v.exp_q = x;
    tbl.push_back(v);
  endtask

  int model_q;

  initial begin
    // Directed table: rst, en, load, seed_in, expected q after the edge.
    add(1, 1, 0, 3'b000, 3'b001);  // reset with en high
    add(0, 1, 0, 3'b000, 3'b010);  // free run, full period
    add(0, 1, 0, 3'b000, 3'b101);
    add(0, 1, 0, 3'b000, 3'b011);
    add(0, 1, 0, 3'b000, 3'b111);
    add(0, 1, 0, 3'b000, 3'b110);
    add(0, 1, 0, 3'b000, 3'b100);
    add(0, 1, 0, 3'b000, 3'b001);
    add(0, 1, 0, 3'b000, 3'b010);
    add(0, 1, 0, 3'b000, 3'b101);
    add(0, 0, 0, 3'b000, 3'b101);  // hold for three edges
    add(0, 0, 0, 3'b000, 3'b101);
    add(0, 0, 0, 3'b000, 3'b101);
    add(0, 1, 1, 3'b110, 3'b110);  // load beats en
    add(0, 1, 0, 3'b000, 3'b100);
    add(0, 1, 0, 3'b000, 3'b001);
    add(0, 1, 0, 3'b000, 3'b010);
    add(0, 1, 0, 3'b000, 3'b101);
    add(0, 1, 0, 3'b000, 3'b011);
    add(0, 1, 0, 3'b000, 3'b111);
    add(1, 1, 0, 3'b000, 3'b001);  // reset mid-run at 111
    add(0, 1, 0, 3'b000, 3'b010);
    add(1, 1, 1, 3'b110, 3'b001);  // reset beats load
    add(0, 0, 1, 3'b011, 3'b011);  // load without en
    add(0, 1, 0, 3'b000, 3'b111);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].load, tbl[i].seed);
      check($sformatf("table[%0d]", i), tbl[i].exp_q);
    end

    // Lockup sequence: zero load with en high, then three enabled edges.
    drive(0, 1, 1, 3'b000);
    check("lockup_load", GUARD ? 3'b001 : 3'b000);
    drive(0, 1, 0, 3'b000);
    check("lockup_step1", GUARD ? 3'b010 : 3'b000);
    drive(0, 1, 0, 3'b000);
    check("lockup_step2", GUARD ? 3'b101 : 3'b000);
    drive(0, 1, 0, 3'b000);
    check("lockup_step3", GUARD ? 3'b011 : 3'b000);
    // A nonzero load always recovers.
    drive(0, 0, 1, 3'b100);
    check("lockup_recover", 3'b100);

    // Randomized traffic against the model.
    model_q = 4;
    for (int i = 0; i < 400; i++) begin
      bit r, e, l;
      int s;
      r = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      s = $urandom_range(0, 7);
      model_q = model_edge(model_q, r, e, l, s);
      exp_q.push_back(W'(model_q));
      drive(r, e, l, W'(s));
      check($sformatf("random[%0d]", i), exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
